mem_initiator: RTL and testbench
================================

Name: mem_initiator

Overview:
- Master-side sequencer for the valid/ready static memory slave: drives valid, wr_rd, addr and wdata, and consumes ready and rdata.
- On start, writes a seeded incrementing pattern over a programmable address window, then reads the window back and compares each word.
- Reports pass/fail, error count, first failing address and handshake timeout.
- Used as a built-in self-test master in front of the memory.

Parameters:
- DEPTH, 1024, number of words in the target memory.
- WIDTH, 32, data width.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- TIMEOUT, 16, maximum cycles to wait for ready on one transfer.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin a test run; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first address of the window; latched at start.
- num_words  input  ADDR_WIDTH+1  window length; latched at start; values above DEPTH are clamped to DEPTH.
- seed  input  WIDTH  pattern seed; latched at start.
- valid  output  1  request valid to memory.
- wr_rd  output  1  1 = write, 0 = read.
- addr  output  ADDR_WIDTH  request address.
- wdata  output  WIDTH  write data.
- rdata  input  WIDTH  read data from memory.
- ready  input  1  memory acknowledge.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  result of the last run; held until the next start.
- err_count  output  ADDR_WIDTH+1  number of miscompares in the last run; saturates at DEPTH.
- first_err_addr  output  ADDR_WIDTH  address of the first miscompare; 0 if none.
- timeout  output  1  the last run aborted on a handshake timeout.

Behaviour:
- Reset (synchronous, any state): FSM to IDLE; valid, wr_rd, addr, wdata, busy, done, pass, err_count, first_err_addr, timeout all 0; internal counters 0.
- Reset mid-run abandons the run immediately; valid is low the cycle after the reset edge.
- All outputs are registered.
- Pattern: word i (0 ≤ i < N) has address (base_addr + i) mod DEPTH and data (seed + i) mod 2^WIDTH.
- Address wrap-around past DEPTH-1 to 0 is legal.
- Transfer handshake: a transfer completes on a rising edge where valid=1 and ready=1.
  - valid, wr_rd, addr and wdata are held stable until completion.
  - After every completed transfer, valid is deasserted for exactly one cycle (GAP state) before the next request. This lets ready fall, so a stale ready is never taken as an acknowledge.
  - For reads, rdata is sampled on the completing edge.
- States:
  - IDLE: if start=1, latch inputs and clear pass, err_count, first_err_addr and timeout. If N=0, go to DONE; else go to WR_REQ with i=0.
  - WR_REQ: valid=1, wr_rd=1. On completion, go to WR_GAP.
  - WR_GAP: valid=0; i=i+1. If i==N, go to RD_REQ with i=0; else go to WR_REQ.
  - RD_REQ: valid=1, wr_rd=0. On completion, compare rdata with the expected word. On mismatch, increment err_count and record first_err_addr if this is the first error. Then go to RD_GAP.
  - RD_GAP: valid=0; i=i+1. If i==N, go to DONE; else go to RD_REQ.
  - DONE: done=1 for one cycle; pass = (err_count==0 && !timeout); busy=0; go to IDLE.
- Timeout: a wait counter increments each cycle in WR_REQ/RD_REQ with ready=0 and clears on completion.
  - When the counter reaches TIMEOUT: drop valid, set timeout=1, go to DONE, so pass=0.
- start while busy is ignored.
- start asserted in the same cycle as DONE is ignored; it is accepted the following cycle if still high.
- Latency: start edge → first valid=1 is 1 cycle. With an ideal slave (ready one cycle after valid), each transfer takes 3 cycles, so a run takes about 6N+2 cycles.

Test Plan:
- Ideal memory model, base_addr=0, num_words=4, seed=32'h100 → writes 0x100..0x103 to addr 0..3, reads them back; done pulse, pass=1, err_count=0, timeout=0.
- Wrap case: base_addr=1022, num_words=4, DEPTH=1024 → addresses 1022, 1023, 0, 1 issued in order; pass=1.
- Fault injection: model flips bit0 on the read of addr 5, with base 4 and num_words 3 → err_count=1, first_err_addr=5, pass=0.
- Timeout: ready held 0 → valid held 16 cycles then dropped; timeout=1, pass=0, done pulses once.
- num_words=0 → no valid ever asserted; done pulses 2 cycles after start, pass=1. A start pulse during a run has no effect.
- Reset asserted mid-RD_REQ → next cycle valid=0, busy=0, pass=0, err_count=0. A fresh start then completes normally.

Source files
------------

// File: rtl/mem_initiator.sv
// Built-in self-test master for a valid/ready static memory slave.
// On start it writes an incrementing pattern (seed + i) over the window
// [base_addr, base_addr + N) with modulo-DEPTH wrap, then reads every word
// back and checks it against the same pattern.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start               begin a run; only honoured in IDLE
//   base_addr           first address of the window (latched at start)
//   num_words           window length, clamped to DEPTH (latched at start)
//   seed                pattern seed (latched at start)
//   valid, wr_rd        request valid; 1 = write, 0 = read
//   addr, wdata         request address and write data
//   rdata, ready        read data and acknowledge from the memory
//   busy, done          run in progress; one-cycle end-of-run pulse
//   pass                last run had no miscompare and no timeout
//   err_count           miscompares in the last run, saturating at DEPTH
//   first_err_addr      address of the first miscompare, 0 if none
//   timeout             last run was aborted by a handshake timeout
module mem_initiator #(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic [WIDTH-1:0]      seed,
  output logic                  valid,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH-1:0]      rdata,
  input  logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  timeout
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] MaxWords = CntW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StWrReq, StWrGap, StRdReq, StRdGap, StDone
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       idx_q, idx_d;
  logic [CntW-1:0]       n_q, n_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0]      seed_q, seed_d;
  logic [WaitW-1:0]      wait_q, wait_d;
  logic                  valid_q, valid_d;
  logic                  wr_rd_q, wr_rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [CntW-1:0]       err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0] first_err_addr_q, first_err_addr_d;
  logic                  timeout_q, timeout_d;

  logic                  xfer;
  logic [CntW-1:0]       n_clamped;
  logic [CntW-1:0]       idx_inc;
  logic [ADDR_WIDTH-1:0] next_addr;

  always_comb begin
    xfer      = valid_q && ready;
    n_clamped = (num_words > MaxWords) ? MaxWords : num_words;
    idx_inc   = idx_q + CntW'(1);
    // Explicit wrap keeps the window correct for non-power-of-two depths.
    next_addr = (addr_q == LastAddr) ? '0 : addr_q + ADDR_WIDTH'(1);

    state_d          = state_q;
    idx_d            = idx_q;
    n_d              = n_q;
    base_d           = base_q;
    seed_d           = seed_q;
    wait_d           = wait_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    pass_d           = pass_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    timeout_d        = timeout_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          n_d              = n_clamped;
          base_d           = base_addr;
          seed_d           = seed;
          idx_d            = '0;
          wait_d           = '0;
          addr_d           = base_addr;
          wdata_d          = seed;
          busy_d           = 1'b1;
          pass_d           = 1'b0;
          err_count_d      = '0;
          first_err_addr_d = '0;
          timeout_d        = 1'b0;
          state_d          = (n_clamped == '0) ? StDone : StWrReq;
        end
      end
      StWrReq, StRdReq: begin
        if (xfer) begin
          wait_d  = '0;
          state_d = (state_q == StWrReq) ? StWrGap : StRdGap;
          // During reads wdata_q carries the expected word.
          if (state_q == StRdReq && rdata != wdata_q) begin
            if (err_count_q != MaxWords) begin
              err_count_d = err_count_q + CntW'(1);
            end
            if (err_count_q == '0) begin
              first_err_addr_d = addr_q;
            end
          end
        end else if (wait_q == WaitLast) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StWrGap: begin
        idx_d = idx_inc;
        if (idx_inc == n_q) begin
          idx_d   = '0;
          addr_d  = base_q;
          wdata_d = seed_q;
          state_d = StRdReq;
        end else begin
          addr_d  = next_addr;
          wdata_d = wdata_q + WIDTH'(1);
          state_d = StWrReq;
        end
      end
      StRdGap: begin
        idx_d = idx_inc;
        if (idx_inc == n_q) begin
          state_d = StDone;
        end else begin
          addr_d  = next_addr;
          wdata_d = wdata_q + WIDTH'(1);
          state_d = StRdReq;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        pass_d  = (err_count_q == '0) && !timeout_q;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Request strobes follow the next state so they are registered yet
    // appear in the first cycle of each request state.
    valid_d = (state_d == StWrReq) || (state_d == StRdReq);
    wr_rd_d = (state_d == StWrReq) || (state_d == StWrGap);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      idx_q            <= '0;
      n_q              <= '0;
      base_q           <= '0;
      seed_q           <= '0;
      wait_q           <= '0;
      valid_q          <= 1'b0;
      wr_rd_q          <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      timeout_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      n_q              <= n_d;
      base_q           <= base_d;
      seed_q           <= seed_d;
      wait_q           <= wait_d;
      valid_q          <= valid_d;
      wr_rd_q          <= wr_rd_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      timeout_q        <= timeout_d;
    end
  end

  assign valid          = valid_q;
  assign wr_rd          = wr_rd_q;
  assign addr           = addr_q;
  assign wdata          = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;
  assign timeout        = timeout_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Scoreboard bench for mem_initiator: a negedge-driven memory model answers
// requests, the stimulus pushes expected transfers and end-of-run results,
// and a monitor pops and compares them as the DUT presents them.
module tb_mem_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] num_words;
  logic [31:0] seed;
  logic        valid;
  logic        wr_rd;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [10:0] err_count;
  logic [9:0]  first_err_addr;
  logic        timeout;

  mem_initiator dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .base_addr      (base_addr),
    .num_words      (num_words),
    .seed           (seed),
    .valid          (valid),
    .wr_rd          (wr_rd),
    .addr           (addr),
    .wdata          (wdata),
    .rdata          (rdata),
    .ready          (ready),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [9:0]  a;
    logic [31:0] d;
  } xfer_t;

  typedef struct {
    logic        pass;
    logic [10:0] errs;
    logic [9:0]  fea;
    logic        to;
  } result_t;

  xfer_t   exp_x[$];
  result_t exp_r[$];

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory model: ready rises one cycle after valid, unless stalled.
  logic [31:0] mem [1024];
  bit stall = 1'b0;
  bit fault_en = 1'b0;
  bit prev_valid = 1'b0;

  always @(negedge clk) begin
    if (valid && prev_valid && !stall) begin
      ready = 1'b1;
      if (wr_rd) mem[addr] = wdata;
      rdata = mem[addr] ^ {31'b0, (fault_en && !wr_rd && addr == 10'd5)};
    end else begin
      ready = 1'b0;
    end
    prev_valid = valid;
  end

  // Monitor: a transfer seen here completes on the coming rising edge.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (valid && ready) begin
        if (exp_x.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL xfer_unexpected: got addr %0d wr %0b, expected none", addr, wr_rd);
        end else begin
          xfer_t e;
          e = exp_x.pop_front();
          check("xfer_wr_rd", wr_rd, e.wr);
          check("xfer_addr", addr, e.a);
          if (e.wr) check("xfer_wdata", wdata, e.d);
        end
      end
      if (done) begin
        if (exp_r.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL done_unexpected: got done pulse, expected none");
        end else begin
          result_t r;
          r = exp_r.pop_front();
          check("res_pass", pass, r.pass);
          check("res_err_count", err_count, r.errs);
          check("res_first_err_addr", first_err_addr, r.fea);
          check("res_timeout", timeout, r.to);
        end
      end
    end
  end

  task automatic push_x(input logic wr, input logic [9:0] a, input logic [31:0] d);
    xfer_t e;
    e.wr = wr;
    e.a  = a;
    e.d  = d;
    exp_x.push_back(e);
  endtask

  task automatic push_r(input logic p, input logic [10:0] errs, input logic [9:0] fea,
                        input logic to);
    result_t r;
    r.pass = p;
    r.errs = errs;
    r.fea  = fea;
    r.to   = to;
    exp_r.push_back(r);
  endtask

  task automatic start_run(input logic [9:0] b, input logic [10:0] n, input logic [31:0] s);
    @(negedge clk);
    base_addr = b;
    num_words = n;
    seed      = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("first_valid", valid, (n != 0));
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(input int budget);
    bit got;
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      #1;
      if (done) got = 1'b1;
    end
    if (!got) begin
      n_vec++;
      n_miss++;
      $display("FAIL wait_done: got no done within %0d cycles, expected a done pulse", budget);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  vcnt;
    bit  found;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    num_words = '0;
    seed      = '0;
    ready     = 1'b0;
    rdata     = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_err_count", err_count, 11'd0);
    check("rst_first_err_addr", first_err_addr, 10'd0);
    check("rst_timeout", timeout, 1'b0);
    rst = 1'b0;

    // Basic run, with a start pulse in the middle that must be ignored.
    push_x(1, 10'd0, 32'h100);
    push_x(1, 10'd1, 32'h101);
    push_x(1, 10'd2, 32'h102);
    push_x(1, 10'd3, 32'h103);
    push_x(0, 10'd0, 32'h100);
    push_x(0, 10'd1, 32'h101);
    push_x(0, 10'd2, 32'h102);
    push_x(0, 10'd3, 32'h103);
    push_r(1, 11'd0, 10'd0, 0);
    start_run(10'd0, 11'd4, 32'h100);
    repeat (4) @(negedge clk);
    base_addr = 10'd77;
    num_words = 11'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100);

    // Address wrap past DEPTH-1 and data wrap past 2^32-1.
    push_x(1, 10'd1022, 32'hFFFF_FFFE);
    push_x(1, 10'd1023, 32'hFFFF_FFFF);
    push_x(1, 10'd0, 32'h0000_0000);
    push_x(1, 10'd1, 32'h0000_0001);
    push_x(0, 10'd1022, 32'hFFFF_FFFE);
    push_x(0, 10'd1023, 32'hFFFF_FFFF);
    push_x(0, 10'd0, 32'h0000_0000);
    push_x(0, 10'd1, 32'h0000_0001);
    push_r(1, 11'd0, 10'd0, 0);
    start_run(10'd1022, 11'd4, 32'hFFFF_FFFE);
    wait_done(100);

    // Corrupted read of address 5.
    fault_en = 1'b1;
    push_x(1, 10'd4, 32'h55);
    push_x(1, 10'd5, 32'h56);
    push_x(1, 10'd6, 32'h57);
    push_x(0, 10'd4, 32'h55);
    push_x(0, 10'd5, 32'h56);
    push_x(0, 10'd6, 32'h57);
    push_r(0, 11'd1, 10'd5, 0);
    start_run(10'd4, 11'd3, 32'h55);
    wait_done(100);
    fault_en = 1'b0;

    // Handshake timeout: valid must stay high for exactly 16 cycles.
    stall = 1'b1;
    push_r(0, 11'd0, 10'd0, 1);
    start_run(10'd0, 11'd2, 32'h10);
    vcnt  = 0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      #1;
      if (valid) vcnt++;
      if (done) found = 1'b1;
    end
    check("timeout_valid_cycles", vcnt, 16);
    check("timeout_done_seen", found, 1'b1);
    stall = 1'b0;

    // Empty window: no requests, done two cycles after start.
    push_r(1, 11'd0, 10'd0, 0);
    start_run(10'd7, 11'd0, 32'h1);
    check("n0_done_early", done, 1'b0);
    @(posedge clk);
    #1;
    check("n0_done", done, 1'b1);
    check("n0_pass", pass, 1'b1);
    check("n0_busy", busy, 1'b0);

    // Reset during the first read request.
    push_x(1, 10'd0, 32'h300);
    push_x(1, 10'd1, 32'h301);
    push_x(1, 10'd2, 32'h302);
    push_x(1, 10'd3, 32'h303);
    start_run(10'd0, 11'd4, 32'h300);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      #1;
      if (valid && !wr_rd && !ready) found = 1'b1;
    end
    check("rd_req_reached", found, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_valid", valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_pass", pass, 1'b0);
    check("midrst_err_count", err_count, 11'd0);
    exp_x.delete();
    exp_r.delete();

    // Fresh run after the reset.
    push_x(1, 10'd8, 32'h40);
    push_x(1, 10'd9, 32'h41);
    push_x(0, 10'd8, 32'h40);
    push_x(0, 10'd9, 32'h41);
    push_r(1, 11'd0, 10'd0, 0);
    start_run(10'd8, 11'd2, 32'h40);
    wait_done(100);

    repeat (3) @(negedge clk);
    check("xfer_queue_drained", exp_x.size(), 0);
    check("result_queue_drained", exp_r.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
